alu_operand_stage: RTL

//  Upstream stage of the qtcore ALU. Owns the 8-bit accumulator (ACC).

---
 rtl/qtcore_pkg.sv | 11 +
 rtl/rd_timeout_ctr.sv | 19 +
 rtl/alu_operand_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/qtcore_pkg.sv
// qtcore_pkg: B-operand source codes, operand-stage state encoding and B selection helper
package qtcore_pkg;
   localparam logic [1:0] BSEL_UNARY = 2'b00;
   localparam logic [1:0] BSEL_IMM   = 2'b01;
   localparam logic [1:0] BSEL_MEM   = 2'b10;
   typedef enum logic [1:0] {IDLE = 2'b00, RD_WAIT = 2'b01, EXEC = 2'b10} state_t;
   // reserved code 11 falls back to a unary (B=0) operand
   function automatic logic [7:0] b_operand(input logic [1:0] bsel, input logic [7:0] imm);
      return bsel == BSEL_IMM ? imm : 8'h00;
   endfunction
endpackage

// File: rtl/rd_timeout_ctr.sv
// rd_timeout_ctr: counts memory-wait cycles and flags the last permitted cycle
module rd_timeout_ctr #(
   parameter int TIMEOUT_CYC = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);
   localparam int W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
   logic [W-1:0] count;
   assign expired = count == LAST;
   always_ff @(posedge clk) begin
      if (rst || clear) count <= '0;
      else if (en && !expired) count <= count + 1'b1;
   end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: owns ACC, gathers the B operand and writes ALU results back
module alu_operand_stage
   import qtcore_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int TIMEOUT_CYC = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_opcode,
   input  logic [1:0]        instr_bsel,
   input  logic [7:0]        instr_imm,
   input  logic [ADDR_W-1:0] instr_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rd_valid,
   input  logic [7:0]        mem_rd_data,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [3:0]        alu_opcode,
   input  logic [7:0]        alu_y,
   input  logic              acc_load_en,
   input  logic [7:0]        acc_load_data,
   output logic [7:0]        acc,
   output logic              zero_flag,
   output logic              done,
   output logic              err
);
   state_t state, state_n;
   logic accept, rd_hit, timeout, expired;
   assign instr_ready = state == IDLE && !acc_load_en;
   assign accept      = instr_valid && instr_ready;
   assign rd_hit      = state == RD_WAIT && mem_rd_valid;
   // data arriving in the final wait cycle still wins over the timeout
   assign timeout     = state == RD_WAIT && !mem_rd_valid && expired;
   rd_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .clear  (state != RD_WAIT),
      .en     (state == RD_WAIT),
      .expired(expired)
   );
   always_comb begin
      state_n = state;
      state_n = accept  ? (instr_bsel == BSEL_MEM ? RD_WAIT : EXEC) :
                rd_hit  ? EXEC :
                timeout ? IDLE :
                state == EXEC ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= '0;
         zero_flag  <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
      end else begin
         state     <= state_n;
         mem_rd_en <= accept && instr_bsel == BSEL_MEM;
         done      <= state == EXEC || timeout;
         if (state == IDLE && acc_load_en) begin
            acc       <= acc_load_data;
            zero_flag <= acc_load_data == 8'h00;
         end else if (state == EXEC) begin
            acc       <= alu_y;
            zero_flag <= alu_y == 8'h00;
         end
         if (accept) begin
            alu_a      <= acc;
            alu_b      <= b_operand(instr_bsel, instr_imm);
            alu_opcode <= instr_opcode;
            if (instr_bsel == BSEL_MEM) mem_addr <= instr_addr;
         end
         if (rd_hit) alu_b <= mem_rd_data;
         if (timeout) err <= 1'b1;
      end
   end
endmodule
